line_arbiter: RTL and testbench
===============================

LINE_ARBITER -- requirements
Module: line_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 3, number of upstream cache-line requesters (2..8).
REQ-002 SHALL have parameter LINE_W, default 256, cache-line data width in bits.
REQ-003 SHALL have parameter ADDR_W, default 32, address width in bits.
REQ-004 SHALL have parameter RR_MODE, default 1: 1 selects round-robin grant, 0 selects fixed priority with the lowest index winning.
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port up_read, input, NUM_PORTS: per-port line read request.
REQ-008 SHALL have port up_write, input, NUM_PORTS: per-port line write request.
REQ-009 SHALL have port up_addr, input, NUM_PORTS x ADDR_W: per-port line address.
REQ-010 SHALL have port up_wdata, input, NUM_PORTS x LINE_W: per-port write line.
REQ-011 SHALL have port up_resp, output, NUM_PORTS: per-port one-cycle completion pulse.
REQ-012 SHALL have port up_rdata, output, LINE_W: read line broadcast to all ports; valid only with the matching up_resp.
REQ-013 SHALL have port mem_read, output, 1: downstream read strobe.
REQ-014 SHALL have port mem_write, output, 1: downstream write strobe.
REQ-015 SHALL have port mem_addr, output, ADDR_W: downstream address.
REQ-016 SHALL have port mem_wdata, output, LINE_W: downstream write line.
REQ-017 SHALL have port mem_resp, input, 1: downstream completion.
REQ-018 SHALL have port mem_rdata, input, LINE_W: downstream read line.
REQ-019 SHALL have port grant_id, output, clog2(NUM_PORTS): index of the port currently served.
REQ-020 SHALL have port busy, output, 1: high while in BUSY or DONE.

Function
REQ-021 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-022 IDLE: when any port has up_read or up_write high, SHALL select a winner, register its index, address, wdata and op, and enter BUSY on the next edge.
REQ-023 Round-robin: the winner SHALL be the first requesting port after the last-granted index, searching upward with wrap from NUM_PORTS-1 to 0; the last-granted pointer SHALL update on every grant.
REQ-024 Fixed priority: the winner SHALL be the lowest-index requesting port; the pointer SHALL be ignored.
REQ-025 A port asserting up_read and up_write together SHALL be served as a write.
REQ-026 BUSY: mem_read or mem_write SHALL be driven from the registered op, with mem_addr and mem_wdata from the registered values, held stable until mem_resp.
REQ-027 BUSY with mem_resp high: up_resp[grant] SHALL pulse in the same cycle, up_rdata SHALL equal mem_rdata, and the FSM SHALL enter DONE.
REQ-028 DONE: SHALL last exactly one cycle with no strobes and no grant, then return to IDLE; this lets the served requester drop its request.
REQ-029 Minimum latency SHALL be 1 cycle from request to mem strobe, plus the downstream latency, plus 1 DONE cycle before the next grant.
REQ-030 Changes to up_* inputs during BUSY SHALL NOT affect the transaction in flight, and a withdrawn request SHALL still receive up_resp.
REQ-031 mem_resp SHALL be ignored in IDLE and DONE.
REQ-032 Outside BUSY, mem_read, mem_write and up_resp SHALL be 0.

Reset
REQ-033 On rst, the FSM SHALL go to IDLE, the pointer to NUM_PORTS-1 (so port 0 wins first), and grant_id, busy, mem_read, mem_write, mem_addr, mem_wdata and up_resp to 0.
REQ-034 Reset during BUSY SHALL abandon the transaction: no up_resp is produced, and a late mem_resp is ignored.

Structure
REQ-035 The shared package SHALL hold the arb_state_t enum (IDLE, BUSY, DONE) and the default LINE_W and ADDR_W constants.
REQ-036 Winner selection SHALL be a combinational sub-module rr_picker, taking the request vector, pointer and mode, and returning the index and a valid flag.

Verification
REQ-037 Single read: port1 reads 0x0000_1040; mem_resp 3 cycles later with rdata=0xA5..A5 -> mem_read on cycle+1 and up_resp[1] pulses with up_rdata=0xA5..A5.
REQ-038 Round-robin: ports 0, 1 and 2 request continuously from reset -> grants in order 0, 1, 2, 0, each separated by a DONE cycle.
REQ-039 Fixed priority (RR_MODE=0): ports 0 and 2 request continuously -> port 0 is always granted and port 2 never is.
REQ-040 Read+write conflict: port2 asserts both with addr 0x80 and wdata 0x1234 -> mem_write=1, mem_read=0, mem_wdata=0x1234.
REQ-041 Stability: port0 changes up_addr from 0x100 to 0x200 during BUSY -> mem_addr stays 0x100 until mem_resp.
REQ-042 Reset mid-BUSY: rst pulsed, then mem_resp arrives -> no up_resp is produced; after reset port 0 wins the first grant.

Source files
------------

// File: rtl/line_arbiter_pkg.sv
// Shared types and defaults for the cache-line arbiter.
package line_arbiter_pkg;

  localparam int DEF_LINE_W = 256;
  localparam int DEF_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/line_arbiter_picker.sv
// Combinational winner selection: round-robin after ptr,
// or fixed priority with the lowest index winning.
module rr_picker
  import line_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  input  logic                 rr_mode,
  output logic [IDX_W-1:0]     idx,
  output logic                 valid
);

  function automatic logic [IDX_W-1:0] wrap(input int v);
    return IDX_W'(v % NUM_PORTS);
  endfunction

  // Scan from lowest to highest priority so the last hit wins.
  always_comb begin
    idx   = '0;
    valid = |req;
    if (rr_mode) begin
      for (int k = NUM_PORTS; k >= 1; k--) begin
        if (req[wrap(int'(ptr) + k)]) begin
          idx = wrap(int'(ptr) + k);
        end
      end
    end else begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (req[i]) begin
          idx = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/line_arbiter.sv
// Arbitrates several cache-line requesters onto one memory port,
// one transaction at a time with a DONE gap between grants.
module line_arbiter
  import line_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int LINE_W    = DEF_LINE_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int RR_MODE   = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              up_read,
  input  logic [NUM_PORTS-1:0]              up_write,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  up_addr,
  input  logic [NUM_PORTS-1:0][LINE_W-1:0]  up_wdata,
  output logic [NUM_PORTS-1:0]              up_resp,
  output logic [LINE_W-1:0]                 up_rdata,
  output logic                              mem_read,
  output logic                              mem_write,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [LINE_W-1:0]                 mem_wdata,
  input  logic                              mem_resp,
  input  logic [LINE_W-1:0]                 mem_rdata,
  output logic [$clog2(NUM_PORTS)-1:0]      grant_id,
  output logic                              busy
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  grant_q;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic              grant_en;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [NUM_PORTS-1:0] req;

  assign req = up_read | up_write;

  rr_picker #(
    .NUM_PORTS(NUM_PORTS),
    .IDX_W    (IDX_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .rr_mode(RR_MODE != 0),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign grant_en  = (state == IDLE) && pick_valid;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign up_rdata  = mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A write request takes precedence over a simultaneous read.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= IDX_W'(NUM_PORTS - 1);
      grant_q <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant_en) begin
      ptr     <= pick_idx;
      grant_q <= pick_idx;
      write_q <= up_write[pick_idx];
      addr_q  <= up_addr[pick_idx];
      wdata_q <= up_wdata[pick_idx];
    end
  end

  always_comb begin
    state_nxt = state;
    up_resp   = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    grant_id  = '0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        busy      = 1'b1;
        grant_id  = grant_q;
        mem_read  = !write_q;
        mem_write = write_q;
        if (mem_resp) begin
          state_nxt = DONE;
          if (!rst) begin
            up_resp[grant_q] = 1'b1;
          end
        end
      end
      DONE: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_line_arbiter.sv
// Self-checking bench: directed table, corner sequences and random
// transactions against a transaction-level arbitration model.
module tb_line_arbiter;

  localparam int NP = 3;
  localparam int LW = 256;
  localparam int AW = 32;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0]         up_read;
  logic [NP-1:0]         up_write;
  logic [NP-1:0][AW-1:0] up_addr;
  logic [NP-1:0][LW-1:0] up_wdata;
  logic                  mem_resp;
  logic [LW-1:0]         mem_rdata;

  logic [NP-1:0] up_resp, f_up_resp;
  logic [LW-1:0] up_rdata, f_up_rdata;
  logic          mem_read, f_mem_read;
  logic          mem_write, f_mem_write;
  logic [AW-1:0] mem_addr, f_mem_addr;
  logic [LW-1:0] mem_wdata, f_mem_wdata;
  logic [IW-1:0] grant_id, f_grant_id;
  logic          busy, f_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            port;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [AW-1:0] alt;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
    int            lat;
    logic          exp_wr;
  } vec_t;

  vec_t tbl[5];
  int   rr_seq_a[4] = '{0, 1, 2, 0};
  int   rr_seq_b[4] = '{0, 2, 0, 2};

  always #5 clk = ~clk;

  line_arbiter #(
    .NUM_PORTS(NP), .LINE_W(LW), .ADDR_W(AW), .RR_MODE(1)
  ) dut (
    .clk(clk), .rst(rst),
    .up_read(up_read), .up_write(up_write),
    .up_addr(up_addr), .up_wdata(up_wdata),
    .up_resp(up_resp), .up_rdata(up_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .grant_id(grant_id), .busy(busy)
  );

  line_arbiter #(
    .NUM_PORTS(NP), .LINE_W(LW), .ADDR_W(AW), .RR_MODE(0)
  ) dut_fp (
    .clk(clk), .rst(rst),
    .up_read(up_read), .up_write(up_write),
    .up_addr(up_addr), .up_wdata(up_wdata),
    .up_resp(f_up_resp), .up_rdata(f_up_rdata),
    .mem_read(f_mem_read), .mem_write(f_mem_write),
    .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .grant_id(f_grant_id), .busy(f_busy)
  );

  task automatic chk(input string name, input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rline();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [NP-1:0] onehot(input int p);
    logic [NP-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  // Reference: first requester strictly after the last grant, wrapping.
  function automatic int rr_ref(input logic [NP-1:0] r, input int last);
    for (int k = 1; k <= NP; k++) begin
      if (r[(last + k) % NP]) return (last + k) % NP;
    end
    return -1;
  endfunction

  function automatic int fp_ref(input logic [NP-1:0] r);
    for (int i = 0; i < NP; i++) begin
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic scramble();
    up_read  = NP'($urandom);
    up_write = NP'($urandom);
    for (int i = 0; i < NP; i++) begin
      up_addr[i]  = $urandom;
      up_wdata[i] = rline();
    end
  endtask

  task automatic idle_chk();
    chk("idle_busy", busy, 0);
    chk("idle_rd", mem_read, 0);
    chk("idle_wr", mem_write, 0);
    chk("idle_resp", up_resp, 0);
    chk("idle_fp_resp", f_up_resp, 0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    up_read   = '0;
    up_write  = '0;
    up_addr   = '0;
    up_wdata  = '0;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_rd", mem_read, 0);
    chk("rst_wr", mem_write, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_resp", up_resp, 0);
    rst = 1'b0;
  endtask

  // Called in IDLE with requests driven; returns in DONE.
  task automatic run_txn(input int g, input int fg, input logic wr,
                         input int lat, input logic [LW-1:0] rd,
                         input bit scr, input logic [AW-1:0] alt);
    logic [AW-1:0] a, fa;
    logic [LW-1:0] d, fd;
    logic          fw;
    a  = up_addr[g];
    d  = up_wdata[g];
    fa = up_addr[fg];
    fd = up_wdata[fg];
    fw = up_write[fg];
    step();
    chk("busy", busy, 1);
    chk("grant", grant_id, g);
    chk("mem_read", mem_read, !wr);
    chk("mem_write", mem_write, wr);
    chk("mem_addr", mem_addr, a);
    chk("mem_wdata", mem_wdata, d);
    chk("fp_grant", f_grant_id, fg);
    chk("fp_write", f_mem_write, fw);
    chk("fp_addr", f_mem_addr, fa);
    chk("fp_wdata", f_mem_wdata, fd);
    if (scr) scramble();
    else if (alt != '0) up_addr[g] = alt;
    repeat (lat) begin
      step();
      chk("hold_addr", mem_addr, a);
      chk("hold_wdata", mem_wdata, d);
      chk("hold_wr", mem_write, wr);
      chk("hold_rd", mem_read, !wr);
      chk("early_resp", up_resp, 0);
    end
    mem_resp  = 1'b1;
    mem_rdata = rd;
    #1;
    chk("resp", up_resp, onehot(g));
    chk("rdata", up_rdata, rd);
    chk("fp_resp", f_up_resp, onehot(fg));
    step();
    chk("done_busy", busy, 1);
    chk("done_grant", grant_id, 0);
    chk("done_strobe", {mem_read, mem_write}, 0);
    chk("done_resp", up_resp, 0);
    chk("done_fp_resp", f_up_resp, 0);
    mem_resp = 1'b0;
  endtask

  initial begin
    int last;
    int w;
    int fw;
    logic [NP-1:0] r;

    tbl[0] = '{port: 1, rd: 1, wr: 0, addr: 32'h0000_1040, alt: '0,
               wdata: '0, rdata: {32{8'hA5}}, lat: 3, exp_wr: 0};
    tbl[1] = '{port: 2, rd: 1, wr: 1, addr: 32'h80, alt: '0,
               wdata: 256'h1234, rdata: '0, lat: 1, exp_wr: 1};
    tbl[2] = '{port: 0, rd: 1, wr: 0, addr: 32'h100, alt: 32'h200,
               wdata: '0, rdata: {32{8'h5A}}, lat: 3, exp_wr: 0};
    tbl[3] = '{port: 0, rd: 0, wr: 1, addr: 32'hFFFF_FFC0, alt: '0,
               wdata: '1, rdata: '0, lat: 0, exp_wr: 1};
    tbl[4] = '{port: 2, rd: 1, wr: 0, addr: 32'h40, alt: '0,
               wdata: '0, rdata: 256'hDEAD, lat: 0, exp_wr: 0};

    do_reset();
    idle_chk();

    for (int i = 0; i < 5; i++) begin
      up_read  = '0;
      up_write = '0;
      up_read[tbl[i].port]  = tbl[i].rd;
      up_write[tbl[i].port] = tbl[i].wr;
      up_addr[tbl[i].port]  = tbl[i].addr;
      up_wdata[tbl[i].port] = tbl[i].wdata;
      run_txn(tbl[i].port, tbl[i].port, tbl[i].exp_wr,
              tbl[i].lat, tbl[i].rdata, 1'b0, tbl[i].alt);
      up_read  = '0;
      up_write = '0;
      step();
      idle_chk();
    end

    // All three ports request continuously from reset.
    do_reset();
    up_read = 3'b111;
    for (int i = 0; i < NP; i++) begin
      up_addr[i]  = 32'h1000 + 32'(i * 'h40);
      up_wdata[i] = rline();
    end
    for (int k = 0; k < 4; k++) begin
      run_txn(rr_seq_a[k], 0, 1'b0, k % 3, rline(), 1'b0, '0);
      step();
      chk("gap_busy", busy, 0);
    end
    up_read = '0;
    step();

    // Ports 0 and 2 only: round-robin alternates, fixed stays on 0.
    do_reset();
    up_read = 3'b101;
    for (int k = 0; k < 4; k++) begin
      run_txn(rr_seq_b[k], 0, 1'b0, 1, rline(), 1'b0, '0);
      step();
    end
    up_read = '0;
    step();

    // Reset while BUSY abandons the transaction.
    do_reset();
    up_read = 3'b001;
    up_addr[0] = 32'h10;
    run_txn(0, 0, 1'b0, 1, rline(), 1'b0, '0);
    up_read = '0;
    step();
    up_read = 3'b111;
    up_addr[1] = 32'h20;
    up_addr[2] = 32'h30;
    step();
    chk("pre_rst_grant", grant_id, 1);
    chk("pre_rst_fp_grant", f_grant_id, 0);
    rst = 1'b1;
    mem_resp = 1'b1;
    #1;
    chk("rst_cyc_resp", up_resp, 0);
    chk("rst_cyc_fp_resp", f_up_resp, 0);
    step();
    rst = 1'b0;
    #1;
    chk("late_resp", up_resp, 0);
    chk("late_busy", busy, 0);
    chk("late_addr", mem_addr, 0);
    chk("late_rd", mem_read, 0);
    mem_resp = 1'b0;
    run_txn(0, 0, 1'b0, 2, rline(), 1'b0, '0);
    up_read = '0;
    step();
    idle_chk();

    // Random transactions against the reference model.
    do_reset();
    last = NP - 1;
    for (int t = 0; t < 60; t++) begin
      scramble();
      r = up_read | up_write;
      if (r == '0) begin
        step();
        chk("rand_idle", busy, 0);
      end else begin
        w  = rr_ref(r, last);
        fw = fp_ref(r);
        run_txn(w, fw, up_write[w], $urandom_range(0, 4), rline(),
                1'($urandom_range(0, 1)), '0);
        last = w;
        up_read  = '0;
        up_write = '0;
        step();
        idle_chk();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
